// File: rtl/hazard_pkg.sv
// Shared codes and helpers for the ID-stage hazard and forwarding unit.
package hazard_pkg;

    localparam int REG_AW   = 5;
    localparam int OPTYPE_W = 2;

    // Classifies what an instruction writes back. Only DATA and LOAD produce a forwardable rd value.
    typedef enum logic [OPTYPE_W-1:0] {
        OPTYPE_NONE  = 2'b00,
        OPTYPE_DATA  = 2'b01,
        OPTYPE_LOAD  = 2'b10,
        OPTYPE_STORE = 2'b11
    } optype_e;

    // Operand source selects for the ID-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_ALU_EX  = 2'b01,
        FWD_ALU_MEM = 2'b10,
        FWD_LD_MEM  = 2'b11
    } fwd_sel_e;

    // True when a source register is actually read and an older in-flight instruction will write it.
    // Register x0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic writer_match(
        input logic                uses_src,
        input logic [REG_AW-1:0]   rs,
        input logic [REG_AW-1:0]   rd,
        input logic [OPTYPE_W-1:0] optype
    );
        return uses_src && (rs != '0) && (rs == rd) &&
               ((optype == OPTYPE_DATA) || (optype == OPTYPE_LOAD));
    endfunction

    // Youngest producer wins. A load still in EX yields FWD_RF because its data does not exist yet;
    // that case is covered by the stall or by the late store-data path.
    function automatic logic [1:0] fwd_select(
        input logic                match_ex,
        input logic [OPTYPE_W-1:0] optype_ex,
        input logic                match_mem,
        input logic [OPTYPE_W-1:0] optype_mem
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (match_ex && (optype_ex == OPTYPE_DATA))
            sel = FWD_ALU_EX;
        else if (match_ex)
            sel = FWD_RF;
        else if (match_mem && (optype_mem == OPTYPE_LOAD))
            sel = FWD_LD_MEM;
        else if (match_mem && (optype_mem == OPTYPE_DATA))
            sel = FWD_ALU_MEM;
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One pipeline slot of writer tracking: the optype and destination index of the instruction in a stage.
import hazard_pkg::*;

module hazard_stage_reg #(
    parameter int REG_AW   = hazard_pkg::REG_AW,
    parameter int OPTYPE_W = hazard_pkg::OPTYPE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [OPTYPE_W-1:0] optype_d,
    input  logic [REG_AW-1:0]   rd_d,
    output logic [OPTYPE_W-1:0] optype_q,
    output logic [REG_AW-1:0]   rd_q
);

    // Reset and flush both turn the slot into a bubble that can never match a source register.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            optype_q <= '0;
            rd_q     <= '0;
        end else begin
            optype_q <= optype_d;
            rd_q     <= rd_d;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// ID-stage hazard detection: load-use stalls, operand forwarding selects, store-data fix-up, branch flush.
import hazard_pkg::*;

module hazard_fwd_unit #(
    parameter int REG_AW   = hazard_pkg::REG_AW,
    parameter int OPTYPE_W = hazard_pkg::OPTYPE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPTYPE_W-1:0] hazard_optype_ID,
    input  logic                rs1use_ID,
    input  logic                rs2use_ID,
    input  logic [REG_AW-1:0]   rs1_ID,
    input  logic [REG_AW-1:0]   rs2_ID,
    input  logic [REG_AW-1:0]   rd_ID,
    input  logic                Branch_ID,
    output logic                PC_EN_IF,
    output logic                reg_FD_EN,
    output logic                reg_FD_flush,
    output logic                reg_DE_flush,
    output logic [1:0]          forward_ctrl_A,
    output logic [1:0]          forward_ctrl_B,
    output logic                forward_ctrl_ls
);

    logic [OPTYPE_W-1:0] optype_ex;
    logic [REG_AW-1:0]   rd_ex;
    logic [OPTYPE_W-1:0] optype_mem;
    logic [REG_AW-1:0]   rd_mem;
    logic                ls_pend;

    logic match1_ex, match2_ex, match1_mem, match2_mem;
    logic load_use_1, load_use_2, ls_skip, stall;

    // A stalled ID instruction enters EX as a bubble; it is re-presented in ID next cycle.
    hazard_stage_reg #(.REG_AW(REG_AW), .OPTYPE_W(OPTYPE_W)) u_ex_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (stall),
        .optype_d (hazard_optype_ID),
        .rd_d     (rd_ID),
        .optype_q (optype_ex),
        .rd_q     (rd_ex)
    );

    hazard_stage_reg #(.REG_AW(REG_AW), .OPTYPE_W(OPTYPE_W)) u_mem_reg (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .optype_d (optype_ex),
        .rd_d     (rd_ex),
        .optype_q (optype_mem),
        .rd_q     (rd_mem)
    );

    // Dependency detection against both in-flight writers, and the resulting stall decision.
    always_comb begin
        match1_ex  = writer_match(rs1use_ID, rs1_ID, rd_ex,  optype_ex);
        match2_ex  = writer_match(rs2use_ID, rs2_ID, rd_ex,  optype_ex);
        match1_mem = writer_match(rs1use_ID, rs1_ID, rd_mem, optype_mem);
        match2_mem = writer_match(rs2use_ID, rs2_ID, rd_mem, optype_mem);

        load_use_1 = match1_ex && (optype_ex == OPTYPE_LOAD);
        load_use_2 = match2_ex && (optype_ex == OPTYPE_LOAD);

        // A store only needs rs2 as write data, which can be patched in EX from the load in MEM.
        ls_skip = (hazard_optype_ID == OPTYPE_STORE) && load_use_2 && !load_use_1;
        stall   = (load_use_1 || load_use_2) && !ls_skip;
    end

    // Pipeline control and operand selects; a stall freezes IF/ID and swallows any branch redirect.
    always_comb begin
        PC_EN_IF       = !stall;
        reg_FD_EN      = !stall;
        reg_DE_flush   = stall;
        reg_FD_flush   = !stall && Branch_ID;
        forward_ctrl_A = fwd_select(match1_ex, optype_ex, match1_mem, optype_mem);
        forward_ctrl_B = fwd_select(match2_ex, optype_ex, match2_mem, optype_mem);
    end

    // Remember a skipped store so its data is taken from the load once both have advanced one stage.
    always_ff @(posedge clk) begin
        if (!rst)
            ls_pend <= 1'b0;
        else
            ls_pend <= ls_skip;
    end

    assign forward_ctrl_ls = ls_pend;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed scoreboard bench for hazard_fwd_unit: stimulus pushes expectations, a monitor checks them.
module tb_hazard_fwd_unit;

    logic       clk;
    logic       rst;
    logic [1:0] hazard_optype_ID;
    logic       rs1use_ID;
    logic       rs2use_ID;
    logic [4:0] rs1_ID;
    logic [4:0] rs2_ID;
    logic [4:0] rd_ID;
    logic       Branch_ID;
    logic       PC_EN_IF;
    logic       reg_FD_EN;
    logic       reg_FD_flush;
    logic       reg_DE_flush;
    logic [1:0] forward_ctrl_A;
    logic [1:0] forward_ctrl_B;
    logic       forward_ctrl_ls;

    typedef struct {
        string      name;
        logic [8:0] expected;
    } sb_entry_t;

    sb_entry_t sb_queue[$];
    int        compared_count;
    int        mismatch_count;

    hazard_fwd_unit dut (
        .clk              (clk),
        .rst              (rst),
        .hazard_optype_ID (hazard_optype_ID),
        .rs1use_ID        (rs1use_ID),
        .rs2use_ID        (rs2use_ID),
        .rs1_ID           (rs1_ID),
        .rs2_ID           (rs2_ID),
        .rd_ID            (rd_ID),
        .Branch_ID        (Branch_ID),
        .PC_EN_IF         (PC_EN_IF),
        .reg_FD_EN        (reg_FD_EN),
        .reg_FD_flush     (reg_FD_flush),
        .reg_DE_flush     (reg_DE_flush),
        .forward_ctrl_A   (forward_ctrl_A),
        .forward_ctrl_B   (forward_ctrl_B),
        .forward_ctrl_ls  (forward_ctrl_ls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one ID-stage instruction just after a rising edge and queue its hand-computed response.
    task automatic applyStimulus(
        input string      name,
        input logic [1:0] optype,
        input logic       r1u,
        input logic       r2u,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic [4:0] rd,
        input logic       br,
        input logic       exp_stall,
        input logic       exp_fd_flush,
        input logic [1:0] exp_fa,
        input logic [1:0] exp_fb,
        input logic       exp_ls
    );
        sb_entry_t e;
        @(posedge clk);
        #1;
        hazard_optype_ID = optype;
        rs1use_ID        = r1u;
        rs2use_ID        = r2u;
        rs1_ID           = rs1;
        rs2_ID           = rs2;
        rd_ID            = rd;
        Branch_ID        = br;
        e.name     = name;
        e.expected = {!exp_stall, !exp_stall, exp_fd_flush, exp_stall, exp_fa, exp_fb, exp_ls};
        sb_queue.push_back(e);
    endtask

    // Compare the sampled DUT response with one scoreboard entry.
    task automatic checkOutput(input sb_entry_t e);
        logic [8:0] actual;
        actual = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush,
                  forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls};
        compared_count++;
        if (actual !== e.expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got pc/fden/fdfl/deflush/A/B/ls=%b_%b_%b_%b_%b_%b_%b expected %b_%b_%b_%b_%b_%b_%b",
                     e.name, actual[8], actual[7], actual[6], actual[5], actual[4:3], actual[2:1], actual[0],
                     e.expected[8], e.expected[7], e.expected[6], e.expected[5],
                     e.expected[4:3], e.expected[2:1], e.expected[0]);
        end
    endtask

    // Monitor: outputs are combinational, so every pending vector is checked mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (sb_queue.size() > 0) begin
            checkOutput(sb_queue.pop_front());
        end
    end

    initial begin
        compared_count   = 0;
        mismatch_count   = 0;
        rst              = 1'b0;
        hazard_optype_ID = 2'b10;
        rs1use_ID        = 1'b0;
        rs2use_ID        = 1'b0;
        rs1_ID           = 5'd0;
        rs2_ID           = 5'd0;
        rd_ID            = 5'd5;
        Branch_ID        = 1'b0;
        repeat (2) @(posedge clk);

        // Reset held while a load to x5 sat in ID: state must be empty, so reading x5 does not stall
        applyStimulus("reset_state",   2'b00, 1, 0, 5'd5,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b00, 0);
        rst = 1'b1;

        // Load-use: lw x5 ; add x6,x5,x1 stalls once, then forwards load data from MEM
        applyStimulus("lw_x5",         2'b10, 1, 0, 5'd1,  5'd0,  5'd5,  0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("load_use_stall",2'b01, 1, 1, 5'd5,  5'd1,  5'd6,  0, 1, 0, 2'b00, 2'b00, 0);
        applyStimulus("load_use_retry",2'b01, 1, 1, 5'd5,  5'd1,  5'd6,  0, 0, 0, 2'b11, 2'b00, 0);

        // ALU chain: both sources from EX, then mixed EX/MEM, then a one-instruction gap
        applyStimulus("alu_ex_both",   2'b01, 1, 1, 5'd6,  5'd6,  5'd7,  0, 0, 0, 2'b01, 2'b01, 0);
        applyStimulus("alu_ex_mem",    2'b01, 1, 1, 5'd7,  5'd6,  5'd8,  0, 0, 0, 2'b01, 2'b10, 0);
        applyStimulus("nop_gap",       2'b00, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("alu_mem_gap",   2'b01, 1, 1, 5'd0,  5'd8,  5'd9,  0, 0, 0, 2'b00, 2'b10, 0);

        // Store after load: lw x7 ; sw x7,0(x2) skips the stall, store data fixed one cycle later
        applyStimulus("lw_x7",         2'b10, 1, 0, 5'd2,  5'd0,  5'd7,  0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("sw_no_stall",   2'b11, 1, 1, 5'd2,  5'd7,  5'd0,  0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("ls_pend_high",  2'b00, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b00, 1);
        applyStimulus("ls_pend_low",   2'b00, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b00, 0);

        // Branch without hazard flushes IF/ID; branch on a fresh load stalls and holds the flush off
        applyStimulus("branch_flush",  2'b00, 1, 1, 5'd3,  5'd4,  5'd0,  1, 0, 1, 2'b00, 2'b00, 0);
        applyStimulus("lw_x10",        2'b10, 1, 0, 5'd1,  5'd0,  5'd10, 0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("branch_stall",  2'b00, 1, 1, 5'd10, 5'd0,  5'd0,  1, 1, 0, 2'b00, 2'b00, 0);
        applyStimulus("branch_retry",  2'b00, 1, 1, 5'd10, 5'd0,  5'd0,  1, 0, 1, 2'b11, 2'b00, 0);

        // x0 writers never forward; stores in flight are never writers
        applyStimulus("write_x0",      2'b01, 0, 0, 5'd0,  5'd0,  5'd0,  0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("read_x0",       2'b01, 1, 0, 5'd0,  5'd0,  5'd11, 0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("sw_data_fwd",   2'b11, 1, 1, 5'd13, 5'd11, 5'd12, 0, 0, 0, 2'b00, 2'b01, 0);
        applyStimulus("store_ex_nomatch", 2'b01, 1, 1, 5'd12, 5'd11, 5'd14, 0, 0, 0, 2'b00, 2'b10, 0);
        applyStimulus("store_mem_nomatch",2'b01, 1, 0, 5'd12, 5'd0,  5'd15, 0, 0, 0, 2'b00, 2'b00, 0);

        // Same rd in EX and MEM: the younger EX value wins for both identical sources
        applyStimulus("dup_rd_setup",  2'b01, 0, 0, 5'd0,  5'd0,  5'd15, 0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("dup_rd_ex_wins",2'b00, 1, 1, 5'd15, 5'd15, 5'd0,  0, 0, 0, 2'b01, 2'b01, 0);

        // EX ALU result beats an older load to the same register sitting in MEM
        applyStimulus("lw_x16",        2'b10, 1, 0, 5'd15, 5'd0,  5'd16, 0, 0, 0, 2'b10, 2'b00, 0);
        applyStimulus("add_x16",       2'b01, 0, 0, 5'd0,  5'd0,  5'd16, 0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("ex_alu_over_ld",2'b00, 1, 0, 5'd16, 5'd0,  5'd0,  0, 0, 0, 2'b01, 2'b00, 0);

        // Store whose base register also depends on the load must still stall
        applyStimulus("lw_x17",        2'b10, 1, 0, 5'd1,  5'd0,  5'd17, 0, 0, 0, 2'b00, 2'b00, 0);
        applyStimulus("sw_base_stall", 2'b11, 1, 1, 5'd17, 5'd17, 5'd0,  0, 1, 0, 2'b00, 2'b00, 0);
        applyStimulus("sw_base_retry", 2'b11, 1, 1, 5'd17, 5'd17, 5'd0,  0, 0, 0, 2'b11, 2'b11, 0);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb_queue.size() > 0; i++) @(posedge clk);
        if (sb_queue.size() > 0) begin
            mismatch_count++;
            $display("[TB] FAIL drain: %0d entries left unchecked, expected 0", sb_queue.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatch_count);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
